// File: rtl/axis_packet_summarizer.sv
// axis_packet_summarizer
//   Passive AXI-Stream observer. It watches accepted transfers, folds them into
//   one record per TLAST-terminated packet and checks handshake stability
//   during stalls. Records are queued in a small FIFO and drained over a
//   valid/ready summary port. The observed bus is never driven.
//
// Ports
//   ACLK, ARESETn        clock (rising edge), async active-low reset
//   TVALID/TREADY/TLAST  observed handshake and packet boundary
//   TDATA/TSTRB/TKEEP    observed payload (TKEEP popcount gives byte count)
//   TID/TDEST            observed routing fields
//   TREADY_EN            0: bus has no TREADY, every TVALID beat is accepted
//   SUM_VALID/SUM_READY  summary record handshake
//   SUM_BEATS/SUM_BYTES  record counts (saturating)
//   SUM_TID/SUM_TDEST    routing fields latched on the first beat
//   SUM_ERR              {sat, route_err, stable_err, valid_drop}
//   OVERFLOW             sticky: a record was dropped on a full FIFO
//   DROP_CNT             number of dropped records (saturating)
module axis_packet_summarizer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEST_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      TVALID,
  input  logic                      TREADY,
  input  logic                      TLAST,
  input  logic [DATA_WIDTH-1:0]     TDATA,
  input  logic [DATA_WIDTH/8-1:0]   TSTRB,
  input  logic [DATA_WIDTH/8-1:0]   TKEEP,
  input  logic [ID_WIDTH-1:0]       TID,
  input  logic [DEST_WIDTH-1:0]     TDEST,
  input  logic                      TREADY_EN,
  output logic                      SUM_VALID,
  input  logic                      SUM_READY,
  output logic [CNT_WIDTH-1:0]      SUM_BEATS,
  output logic [CNT_WIDTH-1:0]      SUM_BYTES,
  output logic [ID_WIDTH-1:0]       SUM_TID,
  output logic [DEST_WIDTH-1:0]     SUM_TDEST,
  output logic [3:0]                SUM_ERR,
  output logic                      OVERFLOW,
  output logic [CNT_WIDTH-1:0]      DROP_CNT
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, IN_PKT} state_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0]  beats;
    logic [CNT_WIDTH-1:0]  bytes;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [3:0]            err;
  } rec_t;

  function automatic logic [CNT_WIDTH:0] popcount(input logic [STRB_WIDTH-1:0] v);
    logic [CNT_WIDTH:0] n;
    n = '0;
    for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
      n = n + {{CNT_WIDTH{1'b0}}, v[i]};
    end
    return n;
  endfunction

  state_t state_q, state_n;

  logic hs;
  assign hs = TVALID && (TREADY || !TREADY_EN);

  // ---------------------------------------------------------------- stall check
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] s_data;
  logic [STRB_WIDTH-1:0] s_strb, s_keep;
  logic                  s_last;
  logic [ID_WIDTH-1:0]   s_tid;
  logic [DEST_WIDTH-1:0] s_tdest;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stall_q <= 1'b0;
      s_data  <= '0;
      s_strb  <= '0;
      s_keep  <= '0;
      s_last  <= 1'b0;
      s_tid   <= '0;
      s_tdest <= '0;
    end else begin
      stall_q <= TREADY_EN && TVALID && !hs;
      s_data  <= TDATA;
      s_strb  <= TSTRB;
      s_keep  <= TKEEP;
      s_last  <= TLAST;
      s_tid   <= TID;
      s_tdest <= TDEST;
    end
  end

  logic stall_chk, valid_drop, stable_err;
  assign stall_chk  = stall_q && TREADY_EN;
  assign valid_drop = stall_chk && !TVALID;
  assign stable_err = stall_chk && TVALID &&
                      ({TDATA, TSTRB, TKEEP, TLAST, TID, TDEST} !=
                       {s_data, s_strb, s_keep, s_last, s_tid, s_tdest});

  // ------------------------------------------------------------ packet fold
  logic [CNT_WIDTH-1:0]  beats_q, bytes_q;
  logic [ID_WIDTH-1:0]   tid_q;
  logic [DEST_WIDTH-1:0] tdest_q;
  logic [3:0]            err_q;

  logic [CNT_WIDTH:0]    base_beats, base_bytes, beats_sum, bytes_sum;
  logic                  in_pkt, sat_n, route_n;
  logic [3:0]            err_acc, err_rec;
  rec_t                  rec;

  // The counts are computed one bit wider so the carry flags saturation;
  // a first beat starts from zero so the IDLE and IN_PKT paths share one adder.
  always_comb begin
    in_pkt     = (state_q == IN_PKT);
    base_beats = in_pkt ? {1'b0, beats_q} : '0;
    base_bytes = in_pkt ? {1'b0, bytes_q} : '0;
    beats_sum  = base_beats + {{CNT_WIDTH{1'b0}}, 1'b1};
    bytes_sum  = base_bytes + popcount(TKEEP);
    sat_n      = beats_sum[CNT_WIDTH] || bytes_sum[CNT_WIDTH];
    route_n    = in_pkt && ((TID != tid_q) || (TDEST != tdest_q));
    // Stall errors seen while IDLE stay in err_q and land on the next packet.
    err_acc    = err_q | {2'b00, stable_err, valid_drop};
    err_rec    = err_acc | {sat_n, route_n, 2'b00};
    rec.beats  = beats_sum[CNT_WIDTH] ? '1 : beats_sum[CNT_WIDTH-1:0];
    rec.bytes  = bytes_sum[CNT_WIDTH] ? '1 : bytes_sum[CNT_WIDTH-1:0];
    rec.tid    = in_pkt ? tid_q : TID;
    rec.tdest  = in_pkt ? tdest_q : TDEST;
    rec.err    = err_rec;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    if (hs) begin
      state_n = TLAST ? IDLE : IN_PKT;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beats_q <= '0;
      bytes_q <= '0;
      tid_q   <= '0;
      tdest_q <= '0;
      err_q   <= '0;
    end else if (hs) begin
      beats_q <= rec.beats;
      bytes_q <= rec.bytes;
      tid_q   <= rec.tid;
      tdest_q <= rec.tdest;
      err_q   <= TLAST ? 4'b0000 : err_rec;
    end else begin
      err_q   <= err_acc;
    end
  end

  // ------------------------------------------------------------ record FIFO
  rec_t             mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count_q;
  logic             push_req, push, pop, full;

  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop      = (count_q != '0) && SUM_READY;
  assign push_req = hs && TLAST;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr] <= rec;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      OVERFLOW <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_req && !push) begin
        OVERFLOW <= 1'b1;
        if (DROP_CNT != '1) DROP_CNT <= DROP_CNT + 1'b1;
      end
    end
  end

  // Head fields are forced to zero when empty so stale or unwritten entries
  // never reach the port.
  rec_t head;
  assign head      = mem[rd_ptr];
  assign SUM_VALID = (count_q != '0);
  assign SUM_BEATS = SUM_VALID ? head.beats : '0;
  assign SUM_BYTES = SUM_VALID ? head.bytes : '0;
  assign SUM_TID   = SUM_VALID ? head.tid   : '0;
  assign SUM_TDEST = SUM_VALID ? head.tdest : '0;
  assign SUM_ERR   = SUM_VALID ? head.err   : '0;

endmodule
